// File: rtl/pll_reconfig_pkg.sv
// Shared definitions for the PLLE2_ADV DRP reconfiguration sequencer.
package pll_reconfig_pkg;

  localparam int DRP_AW = 7;
  localparam int DRP_DW = 16;

  localparam logic [1:0] ERR_NONE = 2'd0;
  localparam logic [1:0] ERR_DRDY = 2'd1;
  localparam logic [1:0] ERR_LOCK = 2'd2;

  typedef logic [3:0] state_t;

  localparam state_t ST_IDLE      = 4'd0;
  localparam state_t ST_HOLD      = 4'd1;
  localparam state_t ST_RD        = 4'd2;
  localparam state_t ST_WAIT_RD   = 4'd3;
  localparam state_t ST_WR        = 4'd4;
  localparam state_t ST_WAIT_WR   = 4'd5;
  localparam state_t ST_NEXT      = 4'd6;
  localparam state_t ST_REL       = 4'd7;
  localparam state_t ST_WAIT_LOCK = 4'd8;
  localparam state_t ST_DONE      = 4'd9;
  localparam state_t ST_ERR       = 4'd10;

  // Mask bit 1 keeps the value read back from the PLL, 0 takes the new bit.
  function automatic logic [DRP_DW-1:0] drp_merge(input logic [DRP_DW-1:0] rd_val,
                                                  input logic [DRP_DW-1:0] mask,
                                                  input logic [DRP_DW-1:0] data);
    return (rd_val & mask) | (data & ~mask);
  endfunction

endpackage

// File: rtl/pll_drp_reconfig_sync_2ff.sv
// Two-flop synchronizer for asynchronous status inputs such as PLL LOCKED.
module sync_2ff #(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] meta_q, meta_d;
  logic [WIDTH-1:0] sync_q, sync_d;

  // The first stage may go metastable; the second gives it a full cycle to settle.
  always_comb begin
    meta_d = d;
    sync_d = meta_q;
  end

  // Synchronizer stages, cleared by the synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      meta_q <= '0;
      sync_q <= '0;
    end else begin
      meta_q <= meta_d;
      sync_q <= sync_d;
    end
  end

  assign q = sync_q;

endmodule

// File: rtl/pll_drp_reconfig.sv
// Run-time PLLE2_ADV reconfiguration sequencer: holds the PLL in reset,
// read-modify-writes a table of DRP registers, then waits for stable lock.
module pll_drp_reconfig
  import pll_reconfig_pkg::*;
#(
  parameter int NUM_ENTRIES  = 8,
  parameter int RST_HOLD     = 4,
  parameter int DRDY_TIMEOUT = 255,
  parameter int LOCK_TIMEOUT = 65535,
  parameter int LOCK_STABLE  = 16
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             tbl_we,
  input  logic [$clog2(NUM_ENTRIES)-1:0]   tbl_idx,
  input  logic [DRP_AW-1:0]                tbl_addr,
  input  logic [DRP_DW-1:0]                tbl_mask,
  input  logic [DRP_DW-1:0]                tbl_data,
  input  logic                             start,
  input  logic [$clog2(NUM_ENTRIES):0]     count,
  output logic                             busy,
  output logic                             done,
  output logic                             error,
  output logic [1:0]                       err_code,
  output logic [DRP_AW-1:0]                drp_daddr,
  output logic [DRP_DW-1:0]                drp_di,
  input  logic [DRP_DW-1:0]                drp_do,
  output logic                             drp_den,
  output logic                             drp_dwe,
  input  logic                             drp_drdy,
  output logic                             pll_rst,
  input  logic                             pll_locked
);

  localparam int IW  = $clog2(NUM_ENTRIES);
  localparam int CW  = IW + 1;
  localparam int HW  = $clog2(RST_HOLD) + 1;
  localparam int DCW = $clog2(DRDY_TIMEOUT) + 1;
  localparam int LCW = $clog2(LOCK_TIMEOUT) + 1;
  localparam int SCW = $clog2(LOCK_STABLE) + 1;

  localparam logic [CW-1:0]  MAX_CNT     = CW'(NUM_ENTRIES);
  localparam logic [HW-1:0]  HOLD_LAST   = HW'(RST_HOLD - 1);
  localparam logic [DCW-1:0] DRDY_LAST   = DCW'(DRDY_TIMEOUT - 1);
  localparam logic [LCW-1:0] LOCK_LAST   = LCW'(LOCK_TIMEOUT - 1);
  localparam logic [SCW-1:0] STABLE_LAST = SCW'(LOCK_STABLE - 1);

  logic [DRP_AW-1:0] tbl_addr_mem [NUM_ENTRIES];
  logic [DRP_DW-1:0] tbl_mask_mem [NUM_ENTRIES];
  logic [DRP_DW-1:0] tbl_data_mem [NUM_ENTRIES];

  state_t            state_q, state_d;
  logic [CW-1:0]     idx_q, idx_d;
  logic [CW-1:0]     count_q, count_d;
  logic [HW-1:0]     hold_cnt_q, hold_cnt_d;
  logic [DCW-1:0]    drdy_cnt_q, drdy_cnt_d;
  logic [LCW-1:0]    lock_cnt_q, lock_cnt_d;
  logic [SCW-1:0]    stable_cnt_q, stable_cnt_d;
  logic [DRP_AW-1:0] drp_daddr_q, drp_daddr_d;
  logic [DRP_DW-1:0] drp_di_q, drp_di_d;
  logic [1:0]        err_code_q, err_code_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              error_q, error_d;
  logic              drp_den_q, drp_den_d;
  logic              drp_dwe_q, drp_dwe_d;
  logic              pll_rst_q, pll_rst_d;
  logic [CW-1:0]     count_clamped;
  logic              lock_s;

  sync_2ff #(.WIDTH(1)) u_lock_sync (
    .clk (clk),
    .rst (rst),
    .d   (pll_locked),
    .q   (lock_s)
  );

  // Table entries are writable only while no sequence is using them.
  always_ff @(posedge clk) begin
    if (tbl_we && !busy_q) begin
      tbl_addr_mem[tbl_idx] <= tbl_addr;
      tbl_mask_mem[tbl_idx] <= tbl_mask;
      tbl_data_mem[tbl_idx] <= tbl_data;
    end
  end

  // Sequencer next-state: the DRP address/data registers load on the way into RD/WR.
  always_comb begin
    state_d      = state_q;
    idx_d        = idx_q;
    count_d      = count_q;
    hold_cnt_d   = hold_cnt_q;
    drdy_cnt_d   = drdy_cnt_q;
    lock_cnt_d   = lock_cnt_q;
    stable_cnt_d = stable_cnt_q;
    drp_daddr_d  = drp_daddr_q;
    drp_di_d     = drp_di_q;
    err_code_d   = err_code_q;
    count_clamped = (count > MAX_CNT) ? MAX_CNT : count;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          err_code_d = ERR_NONE;
          if (count_clamped == '0) begin
            state_d = ST_DONE;
          end else begin
            state_d    = ST_HOLD;
            count_d    = count_clamped;
            idx_d      = '0;
            hold_cnt_d = '0;
          end
        end
      end
      ST_HOLD: begin
        if (hold_cnt_q >= HOLD_LAST) begin
          state_d     = ST_RD;
          drp_daddr_d = tbl_addr_mem[idx_q[IW-1:0]];
        end else begin
          hold_cnt_d = hold_cnt_q + 1'b1;
        end
      end
      ST_RD: begin
        drdy_cnt_d = '0;
        state_d    = ST_WAIT_RD;
      end
      ST_WAIT_RD: begin
        if (drp_drdy) begin
          state_d  = ST_WR;
          drp_di_d = drp_merge(drp_do, tbl_mask_mem[idx_q[IW-1:0]],
                               tbl_data_mem[idx_q[IW-1:0]]);
        end else if (drdy_cnt_q >= DRDY_LAST) begin
          state_d    = ST_ERR;
          err_code_d = ERR_DRDY;
        end else begin
          drdy_cnt_d = drdy_cnt_q + 1'b1;
        end
      end
      ST_WR: begin
        drdy_cnt_d = '0;
        state_d    = ST_WAIT_WR;
      end
      ST_WAIT_WR: begin
        if (drp_drdy) begin
          state_d = ST_NEXT;
        end else if (drdy_cnt_q >= DRDY_LAST) begin
          state_d    = ST_ERR;
          err_code_d = ERR_DRDY;
        end else begin
          drdy_cnt_d = drdy_cnt_q + 1'b1;
        end
      end
      ST_NEXT: begin
        idx_d = idx_q + 1'b1;
        if (idx_d < count_q) begin
          state_d     = ST_RD;
          drp_daddr_d = tbl_addr_mem[idx_d[IW-1:0]];
        end else begin
          state_d = ST_REL;
        end
      end
      ST_REL: begin
        lock_cnt_d   = '0;
        stable_cnt_d = '0;
        state_d      = ST_WAIT_LOCK;
      end
      ST_WAIT_LOCK: begin
        if (lock_s && (stable_cnt_q >= STABLE_LAST)) begin
          state_d = ST_DONE;
        end else begin
          stable_cnt_d = lock_s ? stable_cnt_q + 1'b1 : '0;
          if (lock_cnt_q >= LOCK_LAST) begin
            state_d    = ST_ERR;
            err_code_d = ERR_LOCK;
          end else begin
            lock_cnt_d = lock_cnt_q + 1'b1;
          end
        end
      end
      ST_DONE: state_d = ST_IDLE;
      ST_ERR:  state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Outputs are decoded from the next state so they leave the block as clean flops.
  always_comb begin
    busy_d    = !((state_d == ST_IDLE) || (state_d == ST_DONE) || (state_d == ST_ERR));
    done_d    = (state_d == ST_DONE);
    error_d   = (state_d == ST_ERR);
    drp_den_d = (state_d == ST_RD) || (state_d == ST_WR);
    drp_dwe_d = (state_d == ST_WR);
    pll_rst_d = (state_d == ST_HOLD) || (state_d == ST_RD) || (state_d == ST_WAIT_RD) ||
                (state_d == ST_WR) || (state_d == ST_WAIT_WR) || (state_d == ST_NEXT);
  end

  // State and output registers; reset aborts any run and releases the PLL.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      idx_q        <= '0;
      count_q      <= '0;
      hold_cnt_q   <= '0;
      drdy_cnt_q   <= '0;
      lock_cnt_q   <= '0;
      stable_cnt_q <= '0;
      drp_daddr_q  <= '0;
      drp_di_q     <= '0;
      err_code_q   <= ERR_NONE;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      error_q      <= 1'b0;
      drp_den_q    <= 1'b0;
      drp_dwe_q    <= 1'b0;
      pll_rst_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      idx_q        <= idx_d;
      count_q      <= count_d;
      hold_cnt_q   <= hold_cnt_d;
      drdy_cnt_q   <= drdy_cnt_d;
      lock_cnt_q   <= lock_cnt_d;
      stable_cnt_q <= stable_cnt_d;
      drp_daddr_q  <= drp_daddr_d;
      drp_di_q     <= drp_di_d;
      err_code_q   <= err_code_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      error_q      <= error_d;
      drp_den_q    <= drp_den_d;
      drp_dwe_q    <= drp_dwe_d;
      pll_rst_q    <= pll_rst_d;
    end
  end

  assign busy      = busy_q;
  assign done      = done_q;
  assign error     = error_q;
  assign err_code  = err_code_q;
  assign drp_daddr = drp_daddr_q;
  assign drp_di    = drp_di_q;
  assign drp_den   = drp_den_q;
  assign drp_dwe   = drp_dwe_q;
  assign pll_rst   = pll_rst_q;

endmodule
